// File: rtl/core_host_ctrl_if.sv
// Host-side bundle for core_host_ctrl: byte streams in/out, data-memory host port, core Start/Done.
// Latency: none, wiring only.
// Backpressure: ready/valid on both byte streams; the memory port has no stall.
interface core_host_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       Start;
    logic       Done;
    logic       busy;
    logic       timeout_err;

    modport master (
        input  in_valid, in_data, out_ready, mem_rdata, Done,
        output in_ready, out_valid, out_data, mem_wr_en, mem_rd_en,
               mem_addr, mem_wdata, Start, busy, timeout_err
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rdata, Done,
        input  in_ready, out_valid, out_data, mem_wr_en, mem_rd_en,
               mem_addr, mem_wdata, Start, busy, timeout_err
    );
endinterface

// File: rtl/core_host_ctrl.sv
// Host-side job sequencer for the 9-bit core: load input bytes, pulse Start, await Done, drain results.
// Latency: memory write one cycle after byte acceptance; result byte valid two cycles after its read issues.
// Backpressure: in_ready low outside LOAD; out_valid/out_data held until out_ready, next read waits for a free slot.
module core_host_ctrl #(
    parameter int LOAD_BASE  = 0,
    parameter int LOAD_LEN   = 64,
    parameter int RES_BASE   = 64,
    parameter int RES_LEN    = 32,
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic               Clk,
    input  logic               Reset,
    core_host_ctrl_if.master   hif
);

    localparam logic [7:0]  LB        = 8'(LOAD_BASE);
    localparam logic [7:0]  RB        = 8'(RES_BASE);
    localparam logic [8:0]  LOAD_LAST = 9'(LOAD_LEN - 1);
    localparam logic [8:0]  RES_END   = 9'(RES_LEN);
    localparam logic [8:0]  RES_LAST  = 9'(RES_LEN - 1);
    localparam logic [31:0] HOLD_LAST = 32'(START_HOLD - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [8:0]  cnt;        // bytes accepted in LOAD, reads issued in DRAIN
    logic [8:0]  cons_cnt;
    logic [31:0] tick;       // cycles spent in START or RUN
    logic        rd_pend;
    logic        wr_en_q;
    logic [7:0]  wr_addr_q;
    logic [7:0]  wdata_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        terr_q;

    logic accept, consume, rd_issue, drain_last;

    assign accept     = (state == S_LOAD) && hif.in_valid;
    assign consume    = out_valid_q && hif.out_ready;
    // A slot being consumed this cycle counts as free, giving one byte per two cycles.
    assign rd_issue   = (state == S_DRAIN) && !rd_pend && (!out_valid_q || hif.out_ready)
                        && (cnt < RES_END);
    assign drain_last = (state == S_DRAIN) && consume && (cons_cnt == RES_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (accept && cnt == LOAD_LAST) state_nxt = S_START;
            S_START: if (tick == HOLD_LAST)          state_nxt = S_RUN;
            // First RUN cycle ignores Done so a stale flag from the last job is dropped.
            S_RUN: begin
                if (tick != '0 && hif.Done)  state_nxt = S_DRAIN;
                else if (tick == TMO_LAST)   state_nxt = S_ERR;
            end
            S_DRAIN: if (drain_last) state_nxt = S_LOAD;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt         <= '0;
            cons_cnt    <= '0;
            tick        <= '0;
            rd_pend     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            terr_q      <= 1'b0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= LB + cnt[7:0];
                wdata_q   <= hif.in_data;
                cnt       <= (cnt == LOAD_LAST) ? 9'd0 : cnt + 9'd1;
            end

            if (state_nxt != state)
                tick <= '0;
            else if (state == S_START || state == S_RUN)
                tick <= tick + 32'd1;

            rd_pend <= rd_issue;
            if (rd_issue)
                cnt <= cnt + 9'd1;

            if (rd_pend) begin
                out_data_q  <= hif.mem_rdata;
                out_valid_q <= 1'b1;
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end

            if (consume)
                cons_cnt <= cons_cnt + 9'd1;
            if (drain_last) begin
                cnt      <= '0;
                cons_cnt <= '0;
            end

            if (state == S_RUN && state_nxt == S_ERR)
                terr_q <= 1'b1;
        end
    end

    always_comb begin
        hif.in_ready    = (state == S_LOAD);
        hif.busy        = (state != S_LOAD);
        hif.Start       = (state == S_START);
        hif.mem_wr_en   = wr_en_q;
        hif.mem_rd_en   = rd_issue;
        hif.mem_addr    = rd_issue ? (RB + cnt[7:0]) : wr_addr_q;
        hif.mem_wdata   = wdata_q;
        hif.out_valid   = out_valid_q;
        hif.out_data    = out_data_q;
        hif.timeout_err = terr_q;
    end

endmodule

// File: tb/tb_core_host_ctrl.sv
// Scoreboard bench for core_host_ctrl: a default-parameter instance runs full jobs against a core model,
// a small instance (base 250, 10 bytes, TIMEOUT 16) covers address wrap, timeout and mid-load reset.
module tb_core_host_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    core_host_ctrl_if ia();
    core_host_ctrl_if ib();

    core_host_ctrl #(.LOAD_BASE(0), .LOAD_LEN(64), .RES_BASE(64), .RES_LEN(32),
                     .START_HOLD(2), .TIMEOUT(4096))
        dut_a (.Clk(clk), .Reset(rst_a), .hif(ia));

    core_host_ctrl #(.LOAD_BASE(250), .LOAD_LEN(10), .RES_BASE(0), .RES_LEN(4),
                     .START_HOLD(2), .TIMEOUT(16))
        dut_b (.Clk(clk), .Reset(rst_b), .hif(ib));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_wr_a[$];
    logic [15:0] exp_wr_b[$];
    logic [7:0]  exp_out_a[$];

    // Job knobs written only by the main process.
    int         done_at    = 100;
    bit         keep_stale = 1'b0;
    int         ready_mode = 0;
    logic [7:0] res_pat    = 8'hA0;

    // Written only by the core model / monitors.
    int start_hold_seen = 0;
    int run_start_cyc   = 0;
    int rd_cnt_a = 0, first_rd_cyc = 0;
    int cons_cnt_a = 0, first_cons_cyc = 0, last_cons_cyc = 0;
    int runb_start_cyc = 0, terr_rise_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Result region of the data memory as filled by the core: byte i of the region reads res_pat+i.
    always @(posedge clk)
        if (ia.mem_rd_en) ia.mem_rdata <= res_pat + (ia.mem_addr - 8'd64);

    initial ib.mem_rdata = 8'h00;

    initial begin
        ia.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ia.out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // Core model: measures the Start pulse, then raises Done done_at cycles into RUN.
    initial begin
        int hold;
        ia.Done = 1'b0;
        forever begin
            @(negedge clk);
            if (ia.Start === 1'b1) begin
                if (!keep_stale) ia.Done = 1'b0;
                hold = 1;
                @(negedge clk);
                while (ia.Start) begin hold++; @(negedge clk); end
                start_hold_seen = hold;
                run_start_cyc   = cyc;
                if (keep_stale) begin
                    @(negedge clk);
                    ia.Done = 1'b0;
                    repeat (done_at - 1) @(negedge clk);
                end else begin
                    repeat (done_at) @(negedge clk);
                end
                ia.Done = 1'b1;
            end
        end
    end

    // Monitor A: write/read scoreboards, output stream, hold stability, strobe exclusion.
    bit         hold_pend = 1'b0;
    logic [7:0] held_dat  = 8'h00;
    always @(negedge clk) begin
        logic [15:0] e;
        logic [7:0]  eo;
        if (!rst_a) begin
            chk("a_wr_rd_excl", {31'd0, ia.mem_wr_en & ia.mem_rd_en}, 0);
            if (ia.Start && !ia.busy) chk("a_start_busy", 0, 1);
            if (ia.mem_wr_en) begin
                if (exp_wr_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_wr_unexpected actual=addr 0x%0h data 0x%0h required=none",
                             ia.mem_addr, ia.mem_wdata);
                end else begin
                    e = exp_wr_a.pop_front();
                    chk("a_wr", {16'd0, ia.mem_addr, ia.mem_wdata}, {16'd0, e});
                end
            end
            if (ia.mem_rd_en) begin
                if (rd_cnt_a % 32 == 0) first_rd_cyc = cyc;
                chk("a_rd_addr", {24'd0, ia.mem_addr}, {24'd0, 8'(64 + rd_cnt_a % 32)});
                rd_cnt_a++;
            end
            if (hold_pend) begin
                chk("a_hold_valid", {31'd0, ia.out_valid}, 1);
                chk("a_hold_data", {24'd0, ia.out_data}, {24'd0, held_dat});
            end
            hold_pend = ia.out_valid && !ia.out_ready;
            held_dat  = ia.out_data;
            if (ia.out_valid && ia.out_ready) begin
                if (cons_cnt_a % 32 == 0) first_cons_cyc = cyc;
                last_cons_cyc = cyc;
                cons_cnt_a++;
                if (exp_out_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_out_unexpected actual=0x%0h required=none", ia.out_data);
                end else begin
                    eo = exp_out_a.pop_front();
                    chk("a_out", {24'd0, ia.out_data}, {24'd0, eo});
                end
            end
        end
    end

    // Monitor B: write scoreboard (also live during reset), RUN entry and timeout rise times.
    logic prev_start_b = 1'b0, prev_terr_b = 1'b0;
    always @(negedge clk) begin
        logic [15:0] e;
        if (ib.mem_wr_en === 1'b1) begin
            if (exp_wr_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_wr_unexpected actual=addr 0x%0h data 0x%0h required=none",
                         ib.mem_addr, ib.mem_wdata);
            end else begin
                e = exp_wr_b.pop_front();
                chk("b_wr", {16'd0, ib.mem_addr, ib.mem_wdata}, {16'd0, e});
            end
        end
        if (prev_start_b && ib.Start === 1'b0) runb_start_cyc = cyc;
        if (!prev_terr_b && ib.timeout_err === 1'b1) terr_rise_cyc = cyc;
        prev_start_b = (ib.Start === 1'b1);
        prev_terr_b  = (ib.timeout_err === 1'b1);
    end

    task automatic load_a(input int n, input int mult);
        for (int i = 0; i < n; i++) begin
            chk("a_in_ready_load", {31'd0, ia.in_ready}, 1);
            ia.in_valid = 1'b1;
            ia.in_data  = 8'(i * mult);
            exp_wr_a.push_back({8'(i), 8'(i * mult)});
            @(posedge clk); #1;
        end
        ia.in_valid = 1'b0;
        chk("a_in_ready_after_load", {31'd0, ia.in_ready}, 0);
    endtask

    task automatic load_b(input int n, input logic [7:0] d0, input bit keep);
        for (int i = 0; i < n; i++) begin
            chk("b_in_ready_load", {31'd0, ib.in_ready}, 1);
            ib.in_valid = 1'b1;
            ib.in_data  = d0 + 8'(i);
            exp_wr_b.push_back({8'(250 + i), d0 + 8'(i)});
            @(posedge clk); #1;
        end
        if (keep) ib.in_data = 8'hEE;
        else      ib.in_valid = 1'b0;
    endtask

    task automatic run_job_a(input string name, input int mult, input int exp_rd_rel);
        int n;
        int rd0, cons0;
        rd0   = rd_cnt_a;
        cons0 = cons_cnt_a;
        for (int i = 0; i < 32; i++) exp_out_a.push_back(res_pat + 8'(i));
        load_a(64, mult);
        n = 0;
        while (ia.busy && n < 3000) begin @(posedge clk); #1; n++; end
        chk({name, "_finished"}, {31'd0, ia.busy}, 0);
        chk({name, "_in_ready"}, {31'd0, ia.in_ready}, 1);
        chk({name, "_start_hold"}, start_hold_seen, 2);
        chk({name, "_wr_left"}, exp_wr_a.size(), 0);
        chk({name, "_out_left"}, exp_out_a.size(), 0);
        chk({name, "_reads"}, rd_cnt_a - rd0, 32);
        chk({name, "_bytes"}, cons_cnt_a - cons0, 32);
        chk({name, "_drain_start"}, first_rd_cyc - run_start_cyc, exp_rd_rel);
    endtask

    task automatic wait_terr_b(input string name);
        int n;
        n = 0;
        while (ib.timeout_err !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        repeat (20) @(posedge clk);
        #1;
        chk({name, "_terr"}, {31'd0, ib.timeout_err}, 1);
        chk({name, "_latency"}, terr_rise_cyc - runb_start_cyc, 16);
        chk({name, "_busy"}, {31'd0, ib.busy}, 1);
        chk({name, "_err_quiet"}, {28'd0, ib.in_ready, ib.out_valid, ib.mem_wr_en | ib.mem_rd_en, ib.Start}, 0);
    endtask

    task automatic pulse_rst_b;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        ib.in_valid = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_wr;
        rst_a = 1'b1; rst_b = 1'b1;
        ia.in_valid = 1'b0; ia.in_data = 8'h00;
        ib.in_valid = 1'b0; ib.in_data = 8'h00;
        ib.out_ready = 1'b1; ib.Done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;

        chk("rst_in_ready", {31'd0, ia.in_ready}, 1);
        chk("rst_out", {23'd0, ia.out_valid, ia.out_data}, 0);
        chk("rst_strobes", {30'd0, ia.mem_wr_en, ia.mem_rd_en}, 0);
        chk("rst_addr_wdata", {16'd0, ia.mem_addr, ia.mem_wdata}, 0);
        chk("rst_ctrl", {29'd0, ia.Start, ia.busy, ia.timeout_err}, 0);
        chk("rst_b_ctrl", {29'd0, ib.Start, ib.busy, ib.timeout_err}, 0);

        // Job 1: data = address, Done 100 cycles into RUN, unthrottled drain at one byte per two cycles.
        done_at = 100; keep_stale = 1'b0; ready_mode = 0; res_pat = 8'hA0;
        first_wr = cyc;
        run_job_a("job1", 1, 101);
        chk("job1_out_spacing", last_cons_cyc - first_cons_cyc, 62);
        chk("job1_first_wr_cycle_sane", {31'd0, (first_cyc_ok(first_wr))}, 1);

        // Job 2: out_ready high one cycle in three.
        done_at = 50; ready_mode = 1; res_pat = 8'h20;
        run_job_a("job2", 3, 51);
        ready_mode = 0;

        // Job 3: Done still high from job 2 through START and RUN cycle 0, then low, then high at cycle 10.
        done_at = 10; keep_stale = 1'b1; res_pat = 8'h5C;
        run_job_a("job3", 5, 11);
        keep_stale = 1'b0;

        // Instance B: wrapping load, timeout, sticky error, reset recovery.
        load_b(10, 8'h10, 1'b0);
        chk("b_in_ready_after_load", {31'd0, ib.in_ready}, 0);
        wait_terr_b("b_tmo1");
        pulse_rst_b();
        chk("b_rst_terr", {31'd0, ib.timeout_err}, 0);
        chk("b_rst_busy", {31'd0, ib.busy}, 0);
        chk("b_rst_in_ready", {31'd0, ib.in_ready}, 1);

        // Reset after the 5th byte while in_valid stays high: no further writes, count restarts.
        load_b(5, 8'h40, 1'b1);
        pulse_rst_b();
        repeat (4) @(posedge clk);
        #1;
        chk("b_midrst_wr_left", exp_wr_b.size(), 0);
        chk("b_midrst_state", {30'd0, ib.busy, ib.in_ready}, 1);
        load_b(10, 8'h80, 1'b0);
        wait_terr_b("b_tmo2");
        chk("b_wr_left", exp_wr_b.size(), 0);
        pulse_rst_b();
        chk("b_final_terr", {31'd0, ib.timeout_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic bit first_cyc_ok(input int c);
        return (c > 0);
    endfunction

endmodule
